// File: rtl/dmac_ch0_ctrl.sv
// DMA channel 0 master sequencer: moves data in AHB INCR bursts through a local
// word buffer (read burst in, write burst out) and strobes the register bank.
module dmac_ch0_ctrl #(
  parameter int unsigned BUF_DEPTH = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic        r_HCLK,
  input  logic        r_HRESETn,
  input  logic        CHANNEL_enable,
  input  logic        DMACINTR_mask,
  input  logic [11:0] TS,
  input  logic [2:0]  BS,
  input  logic [31:0] DMAC_C0_SrcAddr_Master,
  input  logic [31:0] DMAC_C0_DestAddr_Master,
  input  logic        sync_grant,
  input  logic        m_HREADY,
  input  logic [31:0] m_HRDATA,
  output logic        m_HBUSREQ,
  output logic [1:0]  m_HTRANS,
  output logic        m_HWRITE,
  output logic [31:0] m_HADDR,
  output logic [2:0]  m_HSIZE,
  output logic [2:0]  m_HBURST,
  output logic [31:0] m_HWDATA,
  output logic        load_DMAC_C0_Addr,
  output logic        buffer_zero_flag,
  output logic        buffer_idx_inc,
  output logic        src_burst_zero_flag,
  output logic        dest_burst_zero_flag,
  output logic        src_addr_inc,
  output logic        dest_addr_inc,
  output logic        TransferSize_dec_flag,
  output logic        CHANNEL_dis_flag,
  output logic        set_DMACINTR_status,
  output logic        DMACINTR
);

  localparam int unsigned WCNT_W = 10;
  localparam int unsigned BEAT_W = IDX_W + 1;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RD_REQ, S_RD_BURST, S_WR_REQ, S_WR_BURST, S_NEXT, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                en_q;
  logic                pending_q, pending_d;
  logic [WCNT_W-1:0]   words_q, words_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic [BEAT_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                dpend_q, dpend_d;
  logic                first_q, first_d;
  logic [31:0]         buf_q [BUF_DEPTH];

  logic                en_rise, wr_side, addr_left, last_beat;
  logic                addr_go, addr_acc, data_done, buf_we;
  logic [BEAT_W-1:0]   burst_len, beats_c;
  logic                ts_unused;

  assign ts_unused = ^TS[1:0];
  assign en_rise   = CHANNEL_enable && !en_q;
  assign wr_side   = (state_q == S_WR_REQ) || (state_q == S_WR_BURST);
  assign addr_left = addr_cnt_q < beats_q;
  assign last_beat = BEAT_W'(idx_q) == (beats_q - BEAT_W'(1));
  assign m_HSIZE   = 3'b010;
  assign m_HBURST  = 3'b001;
  assign DMACINTR  = pending_q && !DMACINTR_mask;

  // Burst length from BS, clipped to the words still to move.
  always_comb begin
    case (BS)
      3'd1:    burst_len = BEAT_W'(4);
      3'd2:    burst_len = BEAT_W'(8);
      3'd3:    burst_len = BEAT_W'(16);
      default: burst_len = BEAT_W'(1);
    endcase
    beats_c = (words_q < WCNT_W'(burst_len)) ? BEAT_W'(words_q) : burst_len;
  end

  always_ff @(posedge r_HCLK or negedge r_HRESETn) begin
    if (!r_HRESETn) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      pending_q  <= 1'b0;
      words_q    <= '0;
      beats_q    <= '0;
      addr_cnt_q <= '0;
      idx_q      <= '0;
      dpend_q    <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      en_q       <= CHANNEL_enable;
      pending_q  <= pending_d;
      words_q    <= words_d;
      beats_q    <= beats_d;
      addr_cnt_q <= addr_cnt_d;
      idx_q      <= idx_d;
      dpend_q    <= dpend_d;
      first_q    <= first_d;
    end
  end

  // Buffer contents need no reset; every word is written before it is read out.
  always_ff @(posedge r_HCLK) begin
    if (buf_we) buf_q[idx_q] <= m_HRDATA;
  end

  always_comb begin
    state_d               = state_q;
    pending_d             = pending_q;
    words_d               = words_q;
    beats_d               = beats_q;
    addr_cnt_d            = addr_cnt_q;
    idx_d                 = idx_q;
    dpend_d               = dpend_q;
    first_d               = first_q;
    m_HBUSREQ             = 1'b0;
    m_HTRANS              = HTRANS_IDLE;
    m_HWRITE              = 1'b0;
    m_HADDR               = '0;
    m_HWDATA              = '0;
    load_DMAC_C0_Addr     = 1'b0;
    buffer_zero_flag      = 1'b0;
    buffer_idx_inc        = 1'b0;
    src_burst_zero_flag   = 1'b0;
    dest_burst_zero_flag  = 1'b0;
    src_addr_inc          = 1'b0;
    dest_addr_inc         = 1'b0;
    TransferSize_dec_flag = 1'b0;
    CHANNEL_dis_flag      = 1'b0;
    set_DMACINTR_status   = 1'b0;
    addr_go               = 1'b0;
    addr_acc              = 1'b0;
    data_done             = 1'b0;
    buf_we                = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_rise) begin
          load_DMAC_C0_Addr    = 1'b1;
          buffer_zero_flag     = 1'b1;
          src_burst_zero_flag  = 1'b1;
          dest_burst_zero_flag = 1'b1;
          words_d    = TS[11:2];
          pending_d  = 1'b0;
          addr_cnt_d = '0;
          idx_d      = '0;
          dpend_d    = 1'b0;
          first_d    = 1'b1;
          state_d    = (TS[11:2] == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: state_d = CHANNEL_enable ? S_RD_REQ : S_IDLE;
      S_RD_REQ, S_WR_REQ: begin
        m_HWRITE  = wr_side;
        m_HADDR   = wr_side ? DMAC_C0_DestAddr_Master : DMAC_C0_SrcAddr_Master;
        m_HBUSREQ = CHANNEL_enable;
        // A restart after grant loss keeps the burst size already in flight.
        if (!wr_side && addr_cnt_q == '0) beats_d = beats_c;
        if (!CHANNEL_enable) state_d = S_IDLE;
        else if (sync_grant && m_HREADY) state_d = wr_side ? S_WR_BURST : S_RD_BURST;
      end
      S_RD_BURST, S_WR_BURST: begin
        m_HWRITE  = wr_side;
        m_HADDR   = wr_side ? DMAC_C0_DestAddr_Master : DMAC_C0_SrcAddr_Master;
        addr_go   = addr_left && sync_grant && CHANNEL_enable;
        addr_acc  = addr_go && m_HREADY;
        data_done = dpend_q && m_HREADY;
        if (addr_go) m_HTRANS = first_q ? HTRANS_NONSEQ : HTRANS_SEQ;
        m_HBUSREQ     = CHANNEL_enable && ((addr_cnt_q + BEAT_W'(addr_acc)) < beats_q);
        src_addr_inc  = addr_acc && !wr_side;
        dest_addr_inc = addr_acc && wr_side;
        if (wr_side && dpend_q) m_HWDATA = buf_q[idx_q];
        dpend_d = addr_acc || (dpend_q && !m_HREADY);
        if (addr_acc) begin
          addr_cnt_d = addr_cnt_q + BEAT_W'(1);
          first_d    = 1'b0;
        end
        if (data_done) begin
          buffer_idx_inc        = 1'b1;
          idx_d                 = idx_q + IDX_W'(1);
          buf_we                = !wr_side;
          TransferSize_dec_flag = wr_side;
        end
        // Exits wait for the outstanding data phase to finish.
        if (!CHANNEL_enable && (!dpend_q || m_HREADY)) begin
          state_d = S_IDLE;
        end else if (data_done && last_beat) begin
          buffer_zero_flag     = 1'b1;
          src_burst_zero_flag  = !wr_side;
          dest_burst_zero_flag = wr_side;
          idx_d      = '0;
          addr_cnt_d = '0;
          first_d    = 1'b1;
          state_d    = wr_side ? S_NEXT : S_WR_REQ;
        end else if (addr_left && !sync_grant && (!dpend_q || m_HREADY)) begin
          first_d = 1'b1;
          state_d = wr_side ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_NEXT: begin
        words_d = words_q - WCNT_W'(beats_q);
        if (!CHANNEL_enable) state_d = S_IDLE;
        else if (words_q == WCNT_W'(beats_q)) state_d = S_DONE;
        else state_d = S_RD_REQ;
      end
      S_DONE: begin
        CHANNEL_dis_flag    = 1'b1;
        set_DMACINTR_status = 1'b1;
        pending_d           = 1'b1;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmac_ch0_ctrl.sv
// Bench for dmac_ch0_ctrl: register-bank model plus a pipelined AHB slave,
// table-driven transfers and hand-written grant/enable/interrupt sequences.
module tb_dmac_ch0_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, mask = 1'b0, grant = 1'b1;
  logic [11:0] ts = '0;
  logic [2:0]  bs = '0;
  logic [31:0] src_cfg = '0, dst_cfg = '0;
  logic [31:0] src_m, dst_m;
  logic        hready;
  logic [31:0] hrdata;

  logic        m_HBUSREQ, m_HWRITE;
  logic [1:0]  m_HTRANS;
  logic [31:0] m_HADDR, m_HWDATA;
  logic [2:0]  m_HSIZE, m_HBURST;
  logic        load_a, buf_zero, idx_inc, src_zero, dst_zero, src_inc, dst_inc;
  logic        ts_dec, dis, set_int, intr;

  always #5 clk = ~clk;

  dmac_ch0_ctrl dut (
    .r_HCLK(clk), .r_HRESETn(rst_n), .CHANNEL_enable(en), .DMACINTR_mask(mask),
    .TS(ts), .BS(bs), .DMAC_C0_SrcAddr_Master(src_m), .DMAC_C0_DestAddr_Master(dst_m),
    .sync_grant(grant), .m_HREADY(hready), .m_HRDATA(hrdata),
    .m_HBUSREQ(m_HBUSREQ), .m_HTRANS(m_HTRANS), .m_HWRITE(m_HWRITE), .m_HADDR(m_HADDR),
    .m_HSIZE(m_HSIZE), .m_HBURST(m_HBURST), .m_HWDATA(m_HWDATA),
    .load_DMAC_C0_Addr(load_a), .buffer_zero_flag(buf_zero), .buffer_idx_inc(idx_inc),
    .src_burst_zero_flag(src_zero), .dest_burst_zero_flag(dst_zero),
    .src_addr_inc(src_inc), .dest_addr_inc(dst_inc), .TransferSize_dec_flag(ts_dec),
    .CHANNEL_dis_flag(dis), .set_DMACINTR_status(set_int), .DMACINTR(intr)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Register bank address model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_m <= '0;
      dst_m <= '0;
    end else if (load_a) begin
      src_m <= src_cfg;
      dst_m <= dst_cfg;
    end else begin
      if (src_inc) src_m <= src_m + 32'd4;
      if (dst_inc) dst_m <= dst_m + 32'd4;
    end
  end

  // Pipelined AHB slave with optional 2-cycle stall on a chosen beat, plus monitors.
  logic        dp_valid, dp_write, prev_stall, prev_wdp;
  logic [31:0] dp_addr, prev_haddr, prev_hwdata;
  logic [1:0]  prev_htrans;
  int stall_left, rd_n, wr_n, rd_stall_at, wr_stall_at;
  int n_src, n_dst, n_tsd, n_dis, n_set, n_breq, n_hold, n_gnt, n_sstr;
  logic [31:0] rd_addr_q[$], wr_addr_q[$], wr_data_q[$], ns_q[$];

  assign hready = (stall_left == 0);
  assign hrdata = (dp_valid && !dp_write) ? mem_f(dp_addr) : 32'hDEAD_BEEF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid <= 1'b0; dp_write <= 1'b0; dp_addr <= '0; stall_left <= 0;
      prev_stall <= 1'b0; prev_wdp <= 1'b0; prev_htrans <= '0;
      prev_haddr <= '0; prev_hwdata <= '0;
    end else begin
      if (m_HTRANS[1] && !grant) n_gnt <= n_gnt + 1;
      if (m_HBUSREQ) n_breq <= n_breq + 1;
      if (src_inc) n_src <= n_src + 1;
      if (dst_inc) n_dst <= n_dst + 1;
      if (ts_dec) n_tsd <= n_tsd + 1;
      if (dis) n_dis <= n_dis + 1;
      if (set_int) n_set <= n_set + 1;
      if (!hready && (src_inc || dst_inc || idx_inc || ts_dec)) n_sstr <= n_sstr + 1;
      if (prev_stall && prev_htrans != 2'b00 && (m_HTRANS != prev_htrans || m_HADDR != prev_haddr))
        n_hold <= n_hold + 1;
      if (prev_stall && prev_wdp && m_HWDATA != prev_hwdata) n_hold <= n_hold + 1;
      prev_stall  <= !hready;
      prev_htrans <= m_HTRANS;
      prev_haddr  <= m_HADDR;
      prev_hwdata <= m_HWDATA;
      prev_wdp    <= dp_valid && dp_write;
      if (stall_left > 0) stall_left <= stall_left - 1;
      if (dp_valid && hready) begin
        if (dp_write) begin
          wr_addr_q.push_back(dp_addr);
          wr_data_q.push_back(m_HWDATA);
        end else rd_addr_q.push_back(dp_addr);
      end
      if (hready) begin
        dp_valid <= m_HTRANS[1];
        if (m_HTRANS[1]) begin
          dp_addr  <= m_HADDR;
          dp_write <= m_HWRITE;
          if (m_HTRANS == 2'b10) ns_q.push_back(m_HADDR);
          if (m_HWRITE) begin
            wr_n <= wr_n + 1;
            if (wr_n + 1 == wr_stall_at) stall_left <= 2;
          end else begin
            rd_n <= rd_n + 1;
            if (rd_n + 1 == rd_stall_at) stall_left <= 2;
          end
        end
      end
    end
  end

  int checks = 0, errors = 0;
  int b_src, b_dst, b_tsd, b_dis, b_set, b_breq, b_hold, b_gnt, b_sstr;
  int b_rdq, b_wrq, b_ns, b_rd, b_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_src = n_src; b_dst = n_dst; b_tsd = n_tsd; b_dis = n_dis; b_set = n_set;
    b_breq = n_breq; b_hold = n_hold; b_gnt = n_gnt; b_sstr = n_sstr;
    b_rdq = rd_addr_q.size(); b_wrq = wr_addr_q.size(); b_ns = ns_q.size();
    b_rd = rd_n; b_wr = wr_n;
  endtask

  // Drop enable, program the channel, then raise enable for a fresh rising edge.
  task automatic start(input logic [11:0] t, input logic [2:0] b, input logic [31:0] s,
                       input logic [31:0] d, input logic m);
    en = 1'b0;
    cyc(2);
    ts = t; bs = b; src_cfg = s; dst_cfg = d; mask = m;
    snap();
    en = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (n_dis == b_dis && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (n_dis == b_dis) begin
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
    cyc(2);
  endtask

  task automatic check_data(input string name, input logic [31:0] s, input logic [31:0] d,
                            input int words);
    int bad = 0;
    if (rd_addr_q.size() - b_rdq != words) bad++;
    if (wr_addr_q.size() - b_wrq != words) bad++;
    if (bad == 0)
      for (int i = 0; i < words; i++) begin
        if (rd_addr_q[b_rdq + i] != s + 32'(4 * i)) bad++;
        if (wr_addr_q[b_wrq + i] != d + 32'(4 * i)) bad++;
        if (wr_data_q[b_wrq + i] != mem_f(s + 32'(4 * i))) bad++;
      end
    chk({name, "_data"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [11:0] ts;
    logic [2:0]  bs;
    logic [31:0] src;
    logic [31:0] dst;
    logic        mask;
    int          rd_stall;
    int          wr_stall;
    int          exp_words;
    int          exp_ns;
    logic        exp_intr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"v4beat",   12'h010, 3'd1, 32'h1000, 32'h2000, 1'b0, 0, 0, 4,  2,  1'b1};
    vecs[1] = '{"v10w_b8",  12'h028, 3'd2, 32'h3000, 32'h4000, 1'b0, 0, 0, 10, 4,  1'b1};
    vecs[2] = '{"vwait",    12'h010, 3'd1, 32'h1000, 32'h2000, 1'b0, 2, 3, 4,  2,  1'b1};
    vecs[3] = '{"v16beat",  12'h040, 3'd3, 32'h5000, 32'h6000, 1'b0, 0, 0, 16, 2,  1'b1};
    vecs[4] = '{"vsingle",  12'h014, 3'd0, 32'h7000, 32'h7100, 1'b0, 0, 0, 5,  10, 1'b1};
    vecs[5] = '{"vbs5mask", 12'h00C, 3'd5, 32'h8000, 32'h8100, 1'b1, 0, 0, 3,  6,  1'b0};
    vecs[6] = '{"vtsodd",   12'h013, 3'd1, 32'h9000, 32'h9800, 1'b0, 1, 1, 4,  2,  1'b1};

    rd_stall_at = 0;
    wr_stall_at = 0;
    cyc(3);
    chk("rst_htrans", 32'(m_HTRANS), 32'd0);
    chk("rst_hbusreq", 32'(m_HBUSREQ), 32'd0);
    chk("rst_haddr", m_HADDR, 32'd0);
    chk("rst_hsize", 32'(m_HSIZE), 32'd2);
    chk("rst_hburst", 32'(m_HBURST), 32'd1);
    chk("rst_intr", 32'(intr), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_htrans", 32'(m_HTRANS), 32'd0);
    chk("post_rst_dis", 32'(n_dis), 32'd0);

    for (int k = 0; k < 7; k++) begin
      rd_stall_at = (vecs[k].rd_stall != 0) ? rd_n + vecs[k].rd_stall : 0;
      wr_stall_at = (vecs[k].wr_stall != 0) ? wr_n + vecs[k].wr_stall : 0;
      start(vecs[k].ts, vecs[k].bs, vecs[k].src, vecs[k].dst, vecs[k].mask);
      wait_done(vecs[k].name);
      chk({vecs[k].name, "_src_inc"}, 32'(n_src - b_src), 32'(vecs[k].exp_words));
      chk({vecs[k].name, "_dst_inc"}, 32'(n_dst - b_dst), 32'(vecs[k].exp_words));
      chk({vecs[k].name, "_ts_dec"}, 32'(n_tsd - b_tsd), 32'(vecs[k].exp_words));
      chk({vecs[k].name, "_nonseq"}, 32'(ns_q.size() - b_ns), 32'(vecs[k].exp_ns));
      chk({vecs[k].name, "_dis"}, 32'(n_dis - b_dis), 32'd1);
      chk({vecs[k].name, "_set_int"}, 32'(n_set - b_set), 32'd1);
      chk({vecs[k].name, "_intr"}, 32'(intr), 32'(vecs[k].exp_intr));
      chk({vecs[k].name, "_hold"}, 32'(n_hold - b_hold), 32'd0);
      chk({vecs[k].name, "_stall_strobe"}, 32'(n_sstr - b_sstr), 32'd0);
      chk({vecs[k].name, "_no_grant_addr"}, 32'(n_gnt - b_gnt), 32'd0);
      chk({vecs[k].name, "_idle_htrans"}, 32'(m_HTRANS), 32'd0);
      check_data(vecs[k].name, vecs[k].src, vecs[k].dst, vecs[k].exp_words);
    end
    rd_stall_at = 0;
    wr_stall_at = 0;

    // Grant lost after the second address of an 8-beat read.
    begin
      int t = 0;
      start(12'h020, 3'd2, 32'hA000, 32'hB000, 1'b0);
      while ((rd_n - b_rd) < 2 && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("gnt_reach_2nd_addr", 32'(rd_n - b_rd), 32'd2);
      grant = 1'b0;
      cyc(3);
      chk("gnt_bus_idle", 32'(m_HTRANS), 32'd0);
      chk("gnt_rd_pending_done", 32'(rd_addr_q.size() - b_rdq), 32'd2);
      chk("gnt_busreq_held", 32'(m_HBUSREQ), 32'd1);
      grant = 1'b1;
      wait_done("gnt");
      chk("gnt_resume_nonseq", (ns_q.size() - b_ns >= 2) ? ns_q[b_ns + 1] : 32'hFFFF_FFFF,
          32'hA008);
      chk("gnt_src_inc", 32'(n_src - b_src), 32'd8);
      chk("gnt_no_grant_addr", 32'(n_gnt - b_gnt), 32'd0);
      check_data("gnt", 32'hA000, 32'hB000, 8);
    end

    // Enable dropped after the first write address is accepted.
    begin
      int t = 0;
      start(12'h020, 3'd2, 32'hC000, 32'hD000, 1'b0);
      while ((wr_n - b_wr) < 1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("endrop_reach_write", 32'(wr_n - b_wr), 32'd1);
      en = 1'b0;
      cyc(4);
      chk("endrop_htrans", 32'(m_HTRANS), 32'd0);
      chk("endrop_busreq", 32'(m_HBUSREQ), 32'd0);
      chk("endrop_writes", 32'(wr_addr_q.size() - b_wrq), 32'd1);
      chk("endrop_wdata", (wr_data_q.size() > b_wrq) ? wr_data_q[b_wrq] : 32'hFFFF_FFFF,
          mem_f(32'hC000));
      chk("endrop_dst_inc", 32'(n_dst - b_dst), 32'd1);
      chk("endrop_dis", 32'(n_dis - b_dis), 32'd0);
      chk("endrop_set_int", 32'(n_set - b_set), 32'd0);
      chk("endrop_intr", 32'(intr), 32'd0);
    end

    // Sub-word size: straight to DONE, masked interrupt, then cleared by re-enable.
    start(12'h003, 3'd1, 32'hE000, 32'hF000, 1'b1);
    cyc(5);
    chk("ts3_dis", 32'(n_dis - b_dis), 32'd1);
    chk("ts3_set_int", 32'(n_set - b_set), 32'd1);
    chk("ts3_busreq", 32'(n_breq - b_breq), 32'd0);
    chk("ts3_src_inc", 32'(n_src - b_src), 32'd0);
    chk("ts3_intr_masked", 32'(intr), 32'd0);
    mask = 1'b0;
    #1;
    chk("ts3_intr_unmasked", 32'(intr), 32'd1);
    start(12'h010, 3'd1, 32'hE000, 32'hF000, 1'b0);
    cyc(1);
    chk("reen_intr_cleared", 32'(intr), 32'd0);
    wait_done("reen");
    chk("reen_intr_set", 32'(intr), 32'd1);
    check_data("reen", 32'hE000, 32'hF000, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
